// File: rtl/ins_fetch_if.sv
// IF-stage bundle: branch redirect and decode stall in, instruction-memory
// req/ack handshake, and the IF/ID register outputs toward decode.
interface ins_fetch_if;
  logic        iPCSrc;
  logic [31:0] iBranchTarget;
  logic        iStall;
  logic        oImemReq;
  logic [31:0] oImemAddr;
  logic        iImemAck;
  logic [31:0] iImemData;
  logic [31:0] oins;
  logic [31:0] o_temp_npc;
  logic        oValid;
  logic [31:0] oPC;

  modport master (
    input  iPCSrc, iBranchTarget, iStall, iImemAck, iImemData,
    output oImemReq, oImemAddr, oins, o_temp_npc, oValid, oPC
  );

  modport slave (
    output iPCSrc, iBranchTarget, iStall, iImemAck, iImemData,
    input  oImemReq, oImemAddr, oins, o_temp_npc, oValid, oPC
  );
endinterface

// File: rtl/ins_fetch.sv
// MIPS instruction-fetch stage: owns the PC, runs one outstanding imem request,
// buffers one word across decode stalls and drains orphaned fetches on redirect.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// FETCH | request at pc outstanding, IF/ID loads on ack
// DRAIN | waiting out the ack of a fetch orphaned by a redirect
// HOLD  | fetched word parked in buffer while decode stalls
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic          clk,
  input logic          rstn,
  ins_fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_drain_addr, w_drain_addr_nxt;
  logic [31:0] r_buf_ins, w_buf_ins_nxt;
  logic [31:0] r_buf_npc, w_buf_npc_nxt;
  logic [31:0] r_ins, w_ins_nxt;
  logic [31:0] r_npc, w_npc_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  assign w_target = bus.iBranchTarget & 32'hFFFF_FFFC;
  assign w_pc_inc = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= 32'h0;
      r_buf_ins    <= 32'h0;
      r_buf_npc    <= 32'h0;
      r_ins        <= NOP_WORD;
      r_npc        <= 32'h0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_buf_ins    <= w_buf_ins_nxt;
      r_buf_npc    <= w_buf_npc_nxt;
      r_ins        <= w_ins_nxt;
      r_npc        <= w_npc_nxt;
      r_valid      <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drain_addr_nxt = r_drain_addr;
    w_buf_ins_nxt    = r_buf_ins;
    w_buf_npc_nxt    = r_buf_npc;
    w_ins_nxt        = r_ins;
    w_npc_nxt        = r_npc;
    w_valid_nxt      = r_valid;

    case (r_state)
      IDLE: w_state_nxt = FETCH;

      FETCH: begin
        if (bus.iPCSrc) begin
          w_pc_nxt    = w_target;
          w_ins_nxt   = NOP_WORD;
          w_npc_nxt   = 32'h0;
          w_valid_nxt = 1'b0;
          if (!bus.iImemAck) begin
            w_drain_addr_nxt = r_pc;
            w_state_nxt      = DRAIN;
          end
        end else if (bus.iImemAck) begin
          w_pc_nxt = w_pc_inc;
          if (bus.iStall) begin
            w_buf_ins_nxt = bus.iImemData;
            w_buf_npc_nxt = w_pc_inc;
            w_state_nxt   = HOLD;
          end else begin
            w_ins_nxt   = bus.iImemData;
            w_npc_nxt   = w_pc_inc;
            w_valid_nxt = 1'b1;
          end
        end else if (!bus.iStall) begin
          w_ins_nxt   = NOP_WORD;
          w_npc_nxt   = 32'h0;
          w_valid_nxt = 1'b0;
        end
      end

      // the drained word is never used; only the ack matters
      DRAIN: begin
        if (bus.iPCSrc) begin
          w_pc_nxt    = w_target;
          w_ins_nxt   = NOP_WORD;
          w_npc_nxt   = 32'h0;
          w_valid_nxt = 1'b0;
        end else if (!bus.iStall) begin
          w_ins_nxt   = NOP_WORD;
          w_npc_nxt   = 32'h0;
          w_valid_nxt = 1'b0;
        end
        if (bus.iImemAck) w_state_nxt = FETCH;
      end

      HOLD: begin
        if (bus.iPCSrc) begin
          w_pc_nxt    = w_target;
          w_ins_nxt   = NOP_WORD;
          w_npc_nxt   = 32'h0;
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH;
        end else if (!bus.iStall) begin
          w_ins_nxt   = r_buf_ins;
          w_npc_nxt   = r_buf_npc;
          w_valid_nxt = 1'b1;
          w_state_nxt = FETCH;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.oImemReq   = (r_state == FETCH) || (r_state == DRAIN);
  assign bus.oImemAddr  = (r_state == DRAIN) ? r_drain_addr : r_pc;
  assign bus.oins       = r_ins;
  assign bus.o_temp_npc = r_npc;
  assign bus.oValid     = r_valid;
  assign bus.oPC        = r_pc;

endmodule
